// File: rtl/gate_stim_checker.sv
// ---------------------------------------------------------------------------
// gate_stim_checker
//
// Purpose:
//   Self-checking stimulus sequencer for a single combinational gate. After
//   an accepted start it drives every input vector 0 .. 2^N_IN-1 into the
//   gate in ascending order. Each vector is held for SETTLE_CYC cycles, and
//   then the gate output is sampled for one cycle and compared with the
//   truth-table value for the operation latched at start. Mismatches are
//   counted in a saturating error counter. The block reports done/pass when
//   the sweep completes.
//
// Parameters:
//   N_IN        number of gate inputs driven (1..8)
//   SETTLE_CYC  cycles each vector is held before sampling (>= 1)
//   CNT_W       width of the saturating error counter
//
// Ports:
//   clk            rising-edge clock
//   rst            synchronous, active-high reset
//   start          begin a sweep (accepted only in IDLE or DONE)
//   op_sel[2:0]    expected function: 0 NOT(bit0), 1 AND, 2 OR, 3 NAND,
//                  4 NOR, 5 XOR, 6 XNOR, 7 BUF(bit0)
//   dut_out        gate output under test
//   dut_in         vector driven to the gate inputs
//   busy           sweep in progress (registered from SETTLE/SAMPLE)
//   done           sweep finished, held until restart or reset
//   pass           done with zero mismatches
//   err_count      saturating mismatch count
//
// Optional feature (macro GATE_STIM_FAILCAP_EN):
//   fail_seen       set on the first mismatch of a sweep
//   first_fail_vec  dut_in captured at the first mismatch of a sweep
// ---------------------------------------------------------------------------
module gate_stim_checker #(
  parameter int N_IN       = 1,
  parameter int SETTLE_CYC = 4,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op_sel,
  input  logic             dut_out,
  output logic [N_IN-1:0]  dut_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count
`ifdef GATE_STIM_FAILCAP_EN
  ,
  output logic             fail_seen,
  output logic [N_IN-1:0]  first_fail_vec
`endif
);

  // Settle counter only needs to reach SETTLE_CYC-1; keep at least one bit.
  localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYC - 1);
  localparam logic [N_IN-1:0]  VEC_LAST = {N_IN{1'b1}};
  localparam logic [CNT_W-1:0] ERR_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [N_IN-1:0]  dut_in_q, dut_in_d;
  logic [SET_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [2:0]       op_q, op_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             expect_bit;
  logic             mismatch;
`ifdef GATE_STIM_FAILCAP_EN
  logic             fail_seen_q, fail_seen_d;
  logic [N_IN-1:0]  ffv_q, ffv_d;
`endif

  // Truth-table value for the latched operation and the vector on the bus.
  // NOT and BUF look at bit 0 only; the reductions span all N_IN bits.
  always_comb begin
    expect_bit = 1'b0;
    case (op_q)
      3'd0: expect_bit = ~dut_in_q[0];
      3'd1: expect_bit = &dut_in_q;
      3'd2: expect_bit = |dut_in_q;
      3'd3: expect_bit = ~&dut_in_q;
      3'd4: expect_bit = ~|dut_in_q;
      3'd5: expect_bit = ^dut_in_q;
      3'd6: expect_bit = ~^dut_in_q;
      default: expect_bit = dut_in_q[0];
    endcase
  end

  always_comb begin
    state_d  = state_q;
    dut_in_d = dut_in_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    op_d     = op_q;
    mismatch = (state_q == SAMPLE) && (dut_out != expect_bit);
`ifdef GATE_STIM_FAILCAP_EN
    fail_seen_d = fail_seen_q;
    ffv_d       = ffv_q;
`endif

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d  = SETTLE;
          dut_in_d = '0;
          cnt_d    = '0;
          err_d    = '0;
          op_d     = op_sel;
`ifdef GATE_STIM_FAILCAP_EN
          fail_seen_d = 1'b0;
          ffv_d       = '0;
`endif
        end
      end

      SETTLE: begin
        if (cnt_q == SET_LAST) begin
          state_d = SAMPLE;
        end else begin
          cnt_d = cnt_q + SET_W'(1);
        end
      end

      SAMPLE: begin
        if (mismatch && (err_q != ERR_MAX)) begin
          err_d = err_q + CNT_W'(1);
        end
`ifdef GATE_STIM_FAILCAP_EN
        if (mismatch && !fail_seen_q) begin
          fail_seen_d = 1'b1;
          ffv_d       = dut_in_q;
        end
`endif
        if (dut_in_q == VEC_LAST) begin
          state_d = DONE;
        end else begin
          dut_in_d = dut_in_q + N_IN'(1);
          cnt_d    = '0;
          state_d  = SETTLE;
        end
      end

      default: state_d = IDLE;
    endcase

    // Status flags are registered from the current state, so they trail
    // the state register by one cycle (done rises one edge after DONE is
    // entered, which gives the 2^N_IN*(SETTLE_CYC+1)+1 latency).
    busy_d = (state_q == SETTLE) || (state_q == SAMPLE);
    done_d = (state_q == DONE);
    pass_d = (state_q == DONE) && (err_q == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      dut_in_q <= '0;
      cnt_q    <= '0;
      err_q    <= '0;
      op_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
`ifdef GATE_STIM_FAILCAP_EN
      fail_seen_q <= 1'b0;
      ffv_q       <= '0;
`endif
    end else begin
      state_q  <= state_d;
      dut_in_q <= dut_in_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      op_q     <= op_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
`ifdef GATE_STIM_FAILCAP_EN
      fail_seen_q <= fail_seen_d;
      ffv_q       <= ffv_d;
`endif
    end
  end

  assign dut_in    = dut_in_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
`ifdef GATE_STIM_FAILCAP_EN
  assign fail_seen      = fail_seen_q;
  assign first_fail_vec = ffv_q;
`endif

endmodule

// File: tb/tb_gate_stim_checker.sv
// ---------------------------------------------------------------------------
// tb_gate_stim_checker
//
// Three checker instances share clock, reset, start and op_sel:
//   u1: N_IN=1, SETTLE_CYC=4, CNT_W=8
//   u2: N_IN=2, SETTLE_CYC=4, CNT_W=8
//   u3: N_IN=3, SETTLE_CYC=2, CNT_W=2 (small counter to reach saturation)
// Each one drives a behavioural gate whose type is chosen by gateType
// (0..7 same encoding as op_sel, 8 = output tied low). Expected values come
// from the gate truth table, the latency formula and vector enumeration.
// Optional ports are exercised when GATE_STIM_FAILCAP_EN is defined.
// ---------------------------------------------------------------------------
module tb_gate_stim_checker;

  localparam int N1 = 1, S1 = 4, C1 = 8;
  localparam int N2 = 2, S2 = 4, C2 = 8;
  localparam int N3 = 3, S3 = 2, C3 = 2;
  localparam int MAXK = 30;

  int nIn[3]    = '{N1, N2, N3};
  int settle[3] = '{S1, S2, S3};
  int cntW[3]   = '{C1, C2, C3};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start;
  logic [2:0] op_sel;
  int         gateType;

  logic [N1-1:0] din1;
  logic [N2-1:0] din2;
  logic [N3-1:0] din3;
  logic out1, out2, out3;
  logic busy1, busy2, busy3;
  logic done1, done2, done3;
  logic pass1, pass2, pass3;
  logic [C1-1:0] err1;
  logic [C2-1:0] err2;
  logic [C3-1:0] err3;
`ifdef GATE_STIM_FAILCAP_EN
  logic fs1, fs2, fs3;
  logic [N1-1:0] ffv1;
  logic [N2-1:0] ffv2;
  logic [N3-1:0] ffv3;
`endif

  int total = 0;
  int bad   = 0;

  // Reference truth table of the gate types over the low n bits of v.
  function automatic logic gateFn(int g, logic [7:0] v, int n);
    logic rAnd, rOr, rXor;
    rAnd = 1'b1;
    rOr  = 1'b0;
    rXor = 1'b0;
    for (int i = 0; i < n; i++) begin
      rAnd = rAnd & v[i];
      rOr  = rOr | v[i];
      rXor = rXor ^ v[i];
    end
    case (g)
      0: return ~v[0];
      1: return rAnd;
      2: return rOr;
      3: return ~rAnd;
      4: return ~rOr;
      5: return rXor;
      6: return ~rXor;
      7: return v[0];
      default: return 1'b0;
    endcase
  endfunction

  assign out1 = gateFn(gateType, 8'(din1), N1);
  assign out2 = gateFn(gateType, 8'(din2), N2);
  assign out3 = gateFn(gateType, 8'(din3), N3);

  gate_stim_checker #(.N_IN(N1), .SETTLE_CYC(S1), .CNT_W(C1)) u1 (
    .clk(clk), .rst(rst), .start(start), .op_sel(op_sel), .dut_out(out1),
    .dut_in(din1), .busy(busy1), .done(done1), .pass(pass1), .err_count(err1)
`ifdef GATE_STIM_FAILCAP_EN
    , .fail_seen(fs1), .first_fail_vec(ffv1)
`endif
  );

  gate_stim_checker #(.N_IN(N2), .SETTLE_CYC(S2), .CNT_W(C2)) u2 (
    .clk(clk), .rst(rst), .start(start), .op_sel(op_sel), .dut_out(out2),
    .dut_in(din2), .busy(busy2), .done(done2), .pass(pass2), .err_count(err2)
`ifdef GATE_STIM_FAILCAP_EN
    , .fail_seen(fs2), .first_fail_vec(ffv2)
`endif
  );

  gate_stim_checker #(.N_IN(N3), .SETTLE_CYC(S3), .CNT_W(C3)) u3 (
    .clk(clk), .rst(rst), .start(start), .op_sel(op_sel), .dut_out(out3),
    .dut_in(din3), .busy(busy3), .done(done3), .pass(pass3), .err_count(err3)
`ifdef GATE_STIM_FAILCAP_EN
    , .fail_seen(fs3), .first_fail_vec(ffv3)
`endif
  );

  // One rising edge, then settle to the falling edge for sampling/driving.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(string tag, logic [31:0] obs, logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Per-edge expectations k edges after the edge that sampled start.
  task automatic checkInst(int id, int k, logic [7:0] din, logic busy, logic done);
    int n, s, lat, vec;
    n   = nIn[id];
    s   = settle[id];
    lat = (1 << n) * (s + 1) + 1;
    vec = k / (s + 1);
    if (vec > (1 << n) - 1) vec = (1 << n) - 1;
    checkOutput($sformatf("u%0d din k=%0d", id + 1, k), 32'(din), 32'(vec));
    checkOutput($sformatf("u%0d busy k=%0d", id + 1, k), 32'(busy),
                32'((k >= 1 && k <= lat - 1) ? 1 : 0));
    checkOutput($sformatf("u%0d done k=%0d", id + 1, k), 32'(done),
                32'((k >= lat) ? 1 : 0));
  endtask

  // End-of-sweep result from enumerating every vector.
  task automatic checkFinal(int id, int op, int gt, logic [7:0] err, logic pass,
                            logic fs, logic [7:0] ffv);
    int mism, first, sat, errExp;
    mism  = 0;
    first = -1;
    sat   = (1 << cntW[id]) - 1;
    for (int v = 0; v < (1 << nIn[id]); v++) begin
      if (gateFn(gt, 8'(v), nIn[id]) != gateFn(op, 8'(v), nIn[id])) begin
        mism++;
        if (first < 0) first = v;
      end
    end
    errExp = (mism > sat) ? sat : mism;
    checkOutput($sformatf("u%0d err op=%0d gt=%0d", id + 1, op, gt), 32'(err), 32'(errExp));
    checkOutput($sformatf("u%0d pass op=%0d gt=%0d", id + 1, op, gt), 32'(pass),
                32'((mism == 0) ? 1 : 0));
`ifdef GATE_STIM_FAILCAP_EN
    checkOutput($sformatf("u%0d fail_seen", id + 1), 32'(fs), 32'((mism > 0) ? 1 : 0));
    checkOutput($sformatf("u%0d first_fail_vec", id + 1), 32'(ffv),
                32'((first < 0) ? 0 : first));
`else
    if (fs !== 1'b0 || ffv !== 8'd0) begin
      total++;
      bad++;
      $error("[TB] FAIL u%0d capture stub observed=%0h expected=0", id + 1, {fs, ffv});
    end
`endif
  endtask

  task automatic checkAllFinal(int op, int gt);
`ifdef GATE_STIM_FAILCAP_EN
    checkFinal(0, op, gt, 8'(err1), pass1, fs1, 8'(ffv1));
    checkFinal(1, op, gt, 8'(err2), pass2, fs2, 8'(ffv2));
    checkFinal(2, op, gt, 8'(err3), pass3, fs3, 8'(ffv3));
`else
    checkFinal(0, op, gt, 8'(err1), pass1, 1'b0, 8'd0);
    checkFinal(1, op, gt, 8'(err2), pass2, 1'b0, 8'd0);
    checkFinal(2, op, gt, 8'(err3), pass3, 1'b0, 8'd0);
`endif
  endtask

  task automatic checkResetState(string tag);
    checkOutput({tag, " din1"}, 32'(din1), 32'd0);
    checkOutput({tag, " din2"}, 32'(din2), 32'd0);
    checkOutput({tag, " din3"}, 32'(din3), 32'd0);
    checkOutput({tag, " err1"}, 32'(err1), 32'd0);
    checkOutput({tag, " err3"}, 32'(err3), 32'd0);
    checkOutput({tag, " busy"}, 32'({busy1, busy2, busy3}), 32'd0);
    checkOutput({tag, " done"}, 32'({done1, done2, done3}), 32'd0);
    checkOutput({tag, " pass"}, 32'({pass1, pass2, pass3}), 32'd0);
`ifdef GATE_STIM_FAILCAP_EN
    checkOutput({tag, " fail_seen"}, 32'({fs1, fs2, fs3}), 32'd0);
    checkOutput({tag, " ffv3"}, 32'(ffv3), 32'd0);
`endif
  endtask

  // Full sweep: start pulse, op_sel scrambled afterwards (must stay latched),
  // random start pulses while every instance is still busy (must be ignored).
  task automatic applyStimulus(int op, int gt);
    op_sel   = 3'(op);
    gateType = gt;
    start    = 1'b1;
    tick();
    start  = 1'b0;
    op_sel = 3'($urandom);
    for (int k = 1; k <= MAXK; k++) begin
      tick();
      checkInst(0, k, 8'(din1), busy1, done1);
      checkInst(1, k, 8'(din2), busy2, done2);
      checkInst(2, k, 8'(din3), busy3, done3);
      start = (k + 1 <= 9) ? 1'($urandom) : 1'b0;
    end
    start = 1'b0;
    checkAllFinal(op, gt);
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    op_sel   = 3'd0;
    gateType = 0;
    @(negedge clk);
    tick();
    tick();
    checkResetState("reset");
    rst = 1'b0;
    tick();

    $display("[TB] directed sweeps");
    applyStimulus(0, 0);
    applyStimulus(7, 0);
    applyStimulus(1, 3);
    applyStimulus(5, 8);

    $display("[TB] reset during SETTLE of vector 1");
    op_sel   = 3'd0;
    gateType = 0;
    start    = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 7; k++) tick();
    checkOutput("pre-reset din1", 32'(din1), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkResetState("midsweep reset");
    applyStimulus(0, 0);

    $display("[TB] start held high");
    op_sel   = 3'd7;
    gateType = 0;
    start    = 1'b1;
    tick();
    for (int k = 1; k <= 10; k++) begin
      tick();
      checkInst(0, k, 8'(din1), busy1, done1);
    end
    checkOutput("held err1 k=10", 32'(err1), 32'd2);
    tick();
    checkOutput("held done1 k=11", 32'(done1), 32'd1);
    checkOutput("held restart din1", 32'(din1), 32'd0);
    checkOutput("held restart err1", 32'(err1), 32'd0);
    tick();
    checkOutput("held busy1 k=12", 32'(busy1), 32'd1);
    checkOutput("held done1 k=12", 32'(done1), 32'd0);
    start = 1'b0;
    rst   = 1'b1;
    tick();
    rst = 1'b0;
    checkResetState("post-held reset");

    $display("[TB] random sweeps");
    for (int r = 0; r < 6; r++) begin
      applyStimulus(int'($urandom_range(0, 7)), int'($urandom_range(0, 8)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gate_stim_checker.md
Name: gate_stim_checker

Overview:
- Clocked stimulus-and-check stage placed directly upstream of a single combinational gate DUT (NOT, AND, OR, etc.).
- Drives every input combination into the gate in ascending order and waits a programmable settle time before sampling the gate output.
- Compares the sampled output against the expected truth-table value for the selected operation.
- Reports an error count and a pass flag, replacing hand-written delay-based stimulus with a self-checking sequencer.

Parameters:
- N_IN, 1, number of gate inputs driven; legal range 1..8.
- SETTLE_CYC, 4, clock cycles held per vector before sampling; minimum 1. SETTLE_CYC x clock period must exceed the DUT propagation delay.
- CNT_W, 8, width of the error counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a sweep; sampled only in IDLE or DONE.
- op_sel  input  3  expected function: 0 NOT(bit0), 1 AND, 2 OR, 3 NAND, 4 NOR, 5 XOR, 6 XNOR, 7 BUF(bit0).
- dut_out  input  1  gate output under test.
- dut_in  output  N_IN  vector driven to gate inputs.
- busy  output  1  high in SETTLE and SAMPLE.
- done  output  1  high in DONE; held until restart or reset.
- pass  output  1  done && err_count==0.
- err_count  output  CNT_W  mismatch count, saturating.

Behaviour:
- One clock domain; reset is synchronous and active-high.
- Reset (any state, including mid-sweep): state=IDLE; dut_in, err_count, settle counter = 0; busy=done=pass=0.
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - start=1 -> SETTLE; dut_in=0; settle counter=0; err_count=0.
- SETTLE:
  - Counter increments each cycle.
  - When counter reaches SETTLE_CYC-1, go to SAMPLE next cycle; dut_in is held stable.
- SAMPLE (one cycle):
  - Compare dut_out with the expected value computed from op_sel and the current dut_in.
  - On mismatch, err_count+1, saturating at 2^CNT_W-1.
  - If dut_in == 2^N_IN-1 -> DONE; otherwise dut_in+1, counter=0 -> SETTLE.
- DONE:
  - dut_in holds its last vector.
  - start=1 -> same transition as from IDLE (err_count cleared, dut_in=0).
- start while busy is ignored.
- op_sel is latched at start; later changes do not affect the running sweep.
- Reductions (AND/OR/XOR and inverses) operate over all N_IN bits. NOT and BUF use bit 0 only.
- Latency: done rises 2^N_IN x (SETTLE_CYC+1) + 1 cycles after the edge that samples start (N_IN=1, SETTLE_CYC=4: 11 cycles).
- dut_out is sampled only in SAMPLE; its value in other states is don't-care.

Optional Feature:
- Macro: GATE_STIM_FAILCAP_EN.
- When defined, two extra outputs are present:
  - fail_seen (1 bit): set on the first mismatch of a sweep.
  - first_fail_vec (N_IN bits): captures dut_in at the first mismatch; later mismatches do not overwrite it.
  - Both are cleared by rst and by an accepted start.
- When undefined: the ports and their logic are absent; all other behaviour is identical.

Test Plan:
1. N_IN=1, SETTLE_CYC=4, op_sel=0, DUT=NOT gate, start pulse -> dut_in 0 then 1; done at cycle 11; err_count=0; pass=1.
2. Same DUT, op_sel=7 (BUF) -> err_count=2, pass=0; with GATE_STIM_FAILCAP_EN: fail_seen=1, first_fail_vec=0.
3. N_IN=2, op_sel=1 (AND), DUT=NAND -> 4 vectors, err_count=4, done at cycle 2^2 x 5 + 1 = 21.
4. rst asserted in SETTLE of vector 1 -> next cycle IDLE with dut_in=0, err_count=0, busy=0; a following start reproduces case 1 exactly.
5. start held high throughout the sweep -> no restart while busy; start while in DONE restarts with err_count cleared and dut_in=0.
6. CNT_W=2, N_IN=3, DUT output tied to constant 0, op_sel=5 (XOR, 4 mismatches) -> err_count saturates at 3, pass=0.
